// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage for the single-issue RV32I NPC core.
//
// Owns the architectural PC. It issues one instruction-memory request at a
// time, registers the response as a record {pc, inst, fault}, and presents
// that record to decode. It also handles three things:
//   - redirects from execute,
//   - misaligned targets and access faults, which become fault records,
//   - ebreak, or a retired fault record, which halts fetch until reset.
//
// Ports
//   clk, rstn               clock, async active-low reset
//   imem_req_valid/ready    fetch request handshake, address imem_req_addr
//   imem_rsp_valid/data/err response (no backpressure, one per request)
//   redirect_valid/pc       PC redirect from execute
//   out_valid/out_ready     record handshake to decode
//   pc_out, mem_inst_out    presented record; out_fault marks a fault record
//   halt                    core halted
//   fetch_cnt               number of records accepted by decode
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] mem_inst_out,
  output logic        out_fault,
  output logic        halt,
  output logic [63:0] fetch_cnt
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_vld_q, req_vld_d;
  logic        ov_q, ov_d;
  logic [31:0] rec_pc_q, rec_pc_d;
  logic [31:0] rec_inst_q, rec_inst_d;
  logic        rec_fault_q, rec_fault_d;
  logic        halt_q, halt_d;
  logic [63:0] cnt_q;

  logic redir, req_fire, out_fire;

  assign redir    = redirect_valid && (state_q != S_HALT);
  assign req_fire = req_vld_q && imem_req_ready;
  // ov_q is only set in HOLD. A redirect there kills the record in the
  // same cycle, so decode never takes a wrong-path instruction.
  assign out_valid = ov_q && !redirect_valid;
  assign out_fire  = out_valid && out_ready;

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = pc_q;
  assign pc_out         = rec_pc_q;
  assign mem_inst_out   = rec_inst_q;
  assign out_fault      = rec_fault_q;
  assign halt           = halt_q;
  assign fetch_cnt      = cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    ov_d        = ov_q;
    rec_pc_d    = rec_pc_q;
    rec_inst_d  = rec_inst_q;
    rec_fault_d = rec_fault_q;
    halt_d      = halt_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (redir) pc_d = redirect_pc;
      end
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          // The old-PC request went out this cycle: its response is stale.
          if (redir) begin
            pc_d   = redirect_pc;
            drop_d = 1'b1;
          end
        end else if (redir) begin
          pc_d = redirect_pc;
        end else if (pc_q[1:0] != 2'b00) begin
          // A misaligned target never reaches memory. It becomes a fault record.
          state_d     = S_HOLD;
          ov_d        = 1'b1;
          rec_pc_d    = pc_q;
          rec_inst_d  = '0;
          rec_fault_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d = redirect_pc;
          // A response in the same cycle is the one outstanding. It is
          // discarded now, so there is nothing left to drop.
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            state_d     = S_HOLD;
            ov_d        = 1'b1;
            rec_pc_d    = pc_q;
            rec_inst_d  = imem_rsp_err ? 32'h0 : imem_rsp_data;
            rec_fault_d = imem_rsp_err;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d    = redirect_pc;
          ov_d    = 1'b0;
          state_d = S_REQ;
        end else if (out_fire) begin
          ov_d = 1'b0;
          if (rec_fault_q || (rec_inst_q == EBREAK)) begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_BOOT;
    endcase
  end

  // The request valid is computed from next-state values, so it stays a
  // plain register and is never raised for a misaligned address.
  assign req_vld_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_vld_q   <= 1'b0;
      ov_q        <= 1'b0;
      rec_pc_q    <= '0;
      rec_inst_q  <= '0;
      rec_fault_q <= 1'b0;
      halt_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      req_vld_q   <= req_vld_d;
      ov_q        <= ov_d;
      rec_pc_q    <= rec_pc_d;
      rec_inst_q  <= rec_inst_d;
      rec_fault_q <= rec_fault_d;
      halt_q      <= halt_d;
      cnt_q       <= cnt_q + {63'd0, out_fire};
    end
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage for the single-issue RV32I NPC core.
- Owns the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready request/response pair.
- Presents each fetched instruction, with its PC, to decode and the trace/debug monitor as `pc_out` / `mem_inst_out`.
- Handles redirects from execute (jal/jalr/taken branch), instruction-access faults and ebreak halt.

## Interface
- `RESET_PC`, 32'h8000_0000: PC of the first fetch after reset.
- `clk`  in  1: clock, all state on rising edge.
- `rstn`  in  1: asynchronous active-low reset.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_req_addr`  out  32: fetch address (word aligned).
- `imem_rsp_valid`  in  1: response valid (no backpressure; exactly one per accepted request).
- `imem_rsp_data`  in  32: fetched instruction word.
- `imem_rsp_err`  in  1: access fault for this response.
- `redirect_valid`  in  1: redirect PC from execute.
- `redirect_pc`  in  32: redirect target.
- `out_valid`  out  1: instruction record valid to decode.
- `out_ready`  in  1: decode accepts record.
- `pc_out`  out  32: PC of presented instruction.
- `mem_inst_out`  out  32: presented instruction word.
- `out_fault`  out  1: record is a fetch fault (misaligned or access error).
- `halt`  out  1: core halted (ebreak or fault retired).
- `fetch_cnt`  out  64: count of records accepted by decode.

## Operation
- States:
  - BOOT: reset state.
  - REQ: `imem_req_valid`=1.
  - WAIT: one request outstanding.
  - HOLD: record registered; `out_valid`=1 unless killed.
  - HALT: terminal.
- Registers:
  - `pc`: next fetch address; `imem_req_addr`=`pc`.
  - `drop`: discard the next response.
  - Output record register.
- Transitions:
  - BOOT -> REQ: first posedge with `rstn` high.
  - REQ -> WAIT: on request handshake.
  - WAIT -> HOLD: on `imem_rsp_valid` with `drop`=0. Capture `pc_out`=`pc` and the data. On `imem_rsp_err`: `mem_inst_out`=0 and `out_fault`=1.
  - WAIT -> REQ: on response with `drop`=1. Response is discarded and `drop` is cleared.
  - HOLD, on decode handshake:
    - Record is ebreak (32'h0010_0073) or a fault -> HALT.
    - Otherwise `pc` <= `pc`+4 (mod 2^32) -> REQ.
  - HALT: no requests, `out_valid`=0, `halt`=1. Exit only by reset.
- Redirect (accepted in BOOT, REQ, WAIT, HOLD; ignored in HALT): `pc` <= `redirect_pc`.
  - REQ with no handshake that cycle: stay REQ. The address changes; memory samples the address only at handshake.
  - REQ with handshake in the same cycle: the old-PC request was accepted; -> WAIT with `drop`=1.
  - WAIT: `drop` <= 1, stay WAIT. A repeated redirect only updates `pc`.
  - HOLD: `out_valid` is forced 0 combinationally that cycle, so no handshake occurs. The held record is discarded -> REQ.
- Misaligned target (`pc`[1:0]!=0) in REQ: no request is issued. Next cycle -> HOLD with a fault record: `pc_out`=`pc`, `mem_inst_out`=0, `out_fault`=1.
- `imem_rsp_valid` outside WAIT is ignored.
- `fetch_cnt` increments on every `out_valid`&&`out_ready`. It wraps at 2^64.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `out_valid`=0, `pc_out`=0, `mem_inst_out`=0, `out_fault`=0.
  - `halt`=0, `fetch_cnt`=0, `drop`=0, state BOOT.
- `rstn` asserted mid-operation returns all of the above immediately. Any outstanding response is ignored because the state is BOOT.
- First `imem_req_valid` is in the second cycle after reset release.
- Request handshake at cycle N with response at N+k: `out_valid` rises at N+k+1.
- Decode handshake at cycle M: next request at M+1.
- With 1-cycle memory and `out_ready` tied high: one instruction per 3 cycles.
- All outputs are registered except the redirect kill on `out_valid`.

## Test plan
- Sequential fetch:
  - Stimulus: 1-cycle memory returning the address as data, `out_ready`=1.
  - Required: `pc_out` 8000_0000, _0004, _0008…; `mem_inst_out` equals its PC; `fetch_cnt` 3 after three records.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles.
  - Required: `out_valid` held with the record stable; no new request until the handshake; then `pc_out` advances by 4.
- Redirect during WAIT:
  - Stimulus: `redirect_pc`=8000_0100 while a request for 8000_0008 is outstanding.
  - Required: that response is dropped; next request addr 8000_0100; next record `pc_out`=8000_0100.
- Redirect in HOLD with `out_ready`=1:
  - Required: `out_valid` 0 that cycle; `fetch_cnt` unchanged; next record is from the target.
- Faults:
  - Stimulus A: `imem_rsp_err` on a response.
  - Required A: record `out_fault`=1, `mem_inst_out`=0; after the handshake `halt`=1 and no further requests.
  - Stimulus B: `redirect_pc`=8000_0102.
  - Required B: fault record with `pc_out`=8000_0102 and no memory request.
- Ebreak and reset:
  - Stimulus: memory returns 0010_0073.
  - Required: record is presented; after the handshake `halt`=1, and a subsequent redirect is ignored.
  - Stimulus: `rstn` low mid-WAIT.
  - Required: all outputs go to reset values; next fetch at `RESET_PC`.
